// File: rtl/alert_escalation_ctrl.sv
// Alarm escalation controller for baby-monitor alert flags: persistence filter, alarm/snooze FSM, buzzer.
// Optional build macro HB_FAST_PATH_EN: heartbeat qualifies on one sample and alarms at urgent level.
module alert_escalation_ctrl #(
  parameter int unsigned PERSIST_CYCLES  = 4,
  parameter int unsigned SNOOZE_CYCLES   = 16,
  parameter int unsigned ESCALATE_CYCLES = 32,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             heartbeat_alert,
  input  logic             temperature_alert,
  input  logic             motion_alert,
  input  logic             ack,
  output logic             alarm_active,
  output logic [1:0]       alarm_level,
  output logic [2:0]       alarm_code,
  output logic             snooze_active,
  output logic             buzzer,
  output logic [CNT_W-1:0] event_count
);

  localparam int ESC_W = $clog2(ESCALATE_CYCLES + 1);
  localparam int SNZ_W = (SNOOZE_CYCLES < 2) ? 1 : $clog2(SNOOZE_CYCLES + 1);
  localparam logic [3:0]       PERSIST_MAX = 4'(PERSIST_CYCLES);
  localparam logic [ESC_W-1:0] ESC_LAST    = ESC_W'(ESCALATE_CYCLES - 1);
  localparam logic [ESC_W-1:0] ESC_SAT     = ESC_W'(ESCALATE_CYCLES);
  localparam logic [SNZ_W-1:0] SNZ_LOAD    = SNZ_W'(SNOOZE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

`ifdef HB_FAST_PATH_EN
  localparam logic       HB_FAST   = 1'b1;
  localparam logic [3:0] HB_THRESH = 4'd1;
`else
  localparam logic       HB_FAST   = 1'b0;
  localparam logic [3:0] HB_THRESH = PERSIST_MAX;
`endif

  typedef enum logic [1:0] {IDLE, ALARM, SNOOZE} state_t;

  logic [2:0]       flags;
  logic [2:0][3:0]  thresh;
  logic [2:0][3:0]  persist_cnt;
  logic [2:0]       qual;

  state_t           state;
  logic [ESC_W-1:0] esc_timer;
  logic [SNZ_W-1:0] snooze_timer;
  logic [1:0]       blink;
  logic [1:0]       blink_nxt;
  logic             snooze_done;
  logic             enter;
  logic             esc_hit;
  logic             hb_join;

  assign flags  = {motion_alert, temperature_alert, heartbeat_alert};
  assign thresh = {PERSIST_MAX, PERSIST_MAX, HB_THRESH};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    qual = '0;
    for (int i = 0; i < 3; i++) qual[i] = (persist_cnt[i] == thresh[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      persist_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!flags[i])     persist_cnt[i] <= '0;
        else if (!qual[i]) persist_cnt[i] <= persist_cnt[i] + 4'd1;
      end
    end
  end

  assign blink_nxt   = blink + 2'd1;
  // The snooze window ends on the edge that would take the timer to zero.
  assign snooze_done = (snooze_timer <= SNZ_W'(1));
  assign enter       = (|qual) && ((state == IDLE) || ((state == SNOOZE) && snooze_done));
  assign esc_hit     = (esc_timer == ESC_LAST);
  assign hb_join     = HB_FAST && qual[0] && !alarm_code[0];

  // Buzzer is registered alongside the level so it never lags a level change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      esc_timer     <= '0;
      snooze_timer  <= '0;
      blink         <= '0;
      alarm_active  <= 1'b0;
      alarm_level   <= 2'd0;
      alarm_code    <= 3'b000;
      snooze_active <= 1'b0;
      buzzer        <= 1'b0;
      event_count   <= '0;
    end else begin
      blink <= blink_nxt;
      if (enter) begin
        state         <= ALARM;
        alarm_active  <= 1'b1;
        snooze_active <= 1'b0;
        snooze_timer  <= '0;
        alarm_code    <= qual;
        esc_timer     <= '0;
        if (HB_FAST && qual[0]) begin
          alarm_level <= 2'd2;
          buzzer      <= 1'b1;
        end else begin
          alarm_level <= 2'd1;
          buzzer      <= blink_nxt[1];
        end
        if (event_count != CNT_MAX) event_count <= event_count + 1'b1;
      end else begin
        case (state)
          ALARM: begin
            if (ack) begin
              state         <= SNOOZE;
              snooze_timer  <= SNZ_LOAD;
              snooze_active <= 1'b1;
              alarm_active  <= 1'b0;
              alarm_level   <= 2'd0;
              alarm_code    <= 3'b000;
              buzzer        <= 1'b0;
            end else begin
              alarm_code <= alarm_code | qual;
              if (esc_timer != ESC_SAT) esc_timer <= esc_timer + 1'b1;
              if ((alarm_level == 2'd2) || esc_hit || hb_join) begin
                alarm_level <= 2'd2;
                buzzer      <= 1'b1;
              end else begin
                buzzer <= blink_nxt[1];
              end
            end
          end
          SNOOZE: begin
            if (snooze_done) begin
              state         <= IDLE;
              snooze_active <= 1'b0;
              snooze_timer  <= '0;
            end else begin
              snooze_timer <= snooze_timer - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alert_escalation_ctrl.sv
// Directed bench for alert_escalation_ctrl (default build): vector table plus multi-cycle sequences.
module tb_alert_escalation_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       hb, tp, mo, ack;
  logic       alarm_active;
  logic [1:0] alarm_level;
  logic [2:0] alarm_code;
  logic       snooze_active;
  logic       buzzer;
  logic [7:0] event_count;

  int passed = 0;
  int total  = 0;
  int edges  = 0;

  typedef struct {
    logic       hb, tp, mo, ack;
    logic       act;
    logic [1:0] lvl;
    logic [2:0] code;
    logic       snz;
    logic [1:0] bz;   // 0/1 literal, 2 = follows blink pattern
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  alert_escalation_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .heartbeat_alert   (hb),
    .temperature_alert (tp),
    .motion_alert      (mo),
    .ack               (ack),
    .alarm_active      (alarm_active),
    .alarm_level       (alarm_level),
    .alarm_code        (alarm_code),
    .snooze_active     (snooze_active),
    .buzzer            (buzzer),
    .event_count       (event_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic act, input logic [1:0] lvl,
                           input logic [2:0] code, input logic snz, input logic bz,
                           input logic [7:0] cnt);
    check({tag, " alarm_active"},  32'(alarm_active),  32'(act));
    check({tag, " alarm_level"},   32'(alarm_level),   32'(lvl));
    check({tag, " alarm_code"},    32'(alarm_code),    32'(code));
    check({tag, " snooze_active"}, 32'(snooze_active), 32'(snz));
    check({tag, " buzzer"},        32'(buzzer),        32'(bz));
    check({tag, " event_count"},   32'(event_count),   32'(cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic drive(input logic h, input logic t, input logic m, input logic a);
    hb  = h;
    tp  = t;
    mo  = m;
    ack = a;
  endtask

  // Free-running blink counter equals edges-since-release mod 4; level-1 buzzer is its MSB.
  function automatic logic blink_bz();
    return logic'((edges % 4) >= 2);
  endfunction

  task automatic add(input logic h, input logic t, input logic m, input logic a,
                     input logic act, input logic [1:0] lvl, input logic [2:0] code,
                     input logic snz, input logic [1:0] bz, input logic [7:0] cnt);
    vq.push_back('{h, t, m, a, act, lvl, code, snz, bz, cnt});
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    check_out("in reset", 0, 0, 3'b000, 0, 0, 0);
    reset = 1'b1;
    edges = 0;

    // Edges 1-5: 3-cycle temperature glitch must not alarm.
    repeat (3) add(0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    repeat (2) add(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    // Edges 6-9: heartbeat filling the persistence counter.
    repeat (4) add(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    // Edges 10-15: warning alarm, buzzer blinking.
    repeat (6) add(1, 0, 0, 0, 1, 1, 3'b001, 0, 2, 1);
    // Edges 16-19: motion filling; edge 20: motion joins the code.
    repeat (4) add(1, 0, 1, 0, 1, 1, 3'b001, 0, 2, 1);
    add(1, 0, 1, 0, 1, 1, 3'b101, 0, 2, 1);

    foreach (vq[i]) begin
      drive(vq[i].hb, vq[i].tp, vq[i].mo, vq[i].ack);
      step();
      check_out($sformatf("vec%0d", i), vq[i].act, vq[i].lvl, vq[i].code, vq[i].snz,
                (vq[i].bz == 2'd2) ? blink_bz() : vq[i].bz[0], vq[i].cnt);
    end

    // Escalation: alarm entered at edge 10, urgent after edge 42.
    while (edges < 41) step();
    check_out("pre-escalate", 1, 1, 3'b101, 0, blink_bz(), 1);
    step();
    check_out("escalate", 1, 2, 3'b101, 0, 1, 1);
    step();
    step();
    check_out("urgent steady", 1, 2, 3'b101, 0, 1, 1);

    // Ack at edge 45, ack ignored in snooze, re-alarm at edge 61.
    drive(1, 0, 1, 1);
    step();
    check_out("ack to snooze", 0, 0, 3'b000, 1, 0, 1);
    drive(1, 0, 1, 0);
    while (edges < 49) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_out("ack in snooze", 0, 0, 3'b000, 1, 0, 1);
    while (edges < 60) step();
    check_out("snooze last", 0, 0, 3'b000, 1, 0, 1);
    step();
    check_out("re-alarm", 1, 1, 3'b101, 0, blink_bz(), 2);

    // Contention: temperature qualifies exactly as ack arrives at edge 66.
    drive(1, 1, 1, 0);
    while (edges < 65) step();
    check_out("before temp join", 1, 1, 3'b101, 0, blink_bz(), 2);
    drive(1, 1, 1, 1);
    step();
    check_out("ack beats join", 0, 0, 3'b000, 1, 0, 2);
    drive(0, 1, 0, 0);
    while (edges < 81) step();
    check_out("snooze2 last", 0, 0, 3'b000, 1, 0, 2);
    step();
    check_out("temp re-alarm", 1, 1, 3'b010, 0, blink_bz(), 3);

    // Ack then drop everything: snooze ends in IDLE with count unchanged.
    drive(0, 1, 0, 1);
    step();
    check_out("ack3", 0, 0, 3'b000, 1, 0, 3);
    drive(0, 0, 0, 0);
    while (edges < 98) step();
    check_out("snooze3 last", 0, 0, 3'b000, 1, 0, 3);
    step();
    check_out("back to idle", 0, 0, 3'b000, 0, 0, 3);

    // Reach urgent alarm again, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 0);
    while (edges < 103) step();
    check_out("hb qualifying", 0, 0, 3'b000, 0, 0, 3);
    step();
    check_out("hb alarm", 1, 1, 3'b001, 0, blink_bz(), 4);
    while (edges < 135) step();
    check_out("hb pre-escalate", 1, 1, 3'b001, 0, blink_bz(), 4);
    step();
    check_out("hb urgent", 1, 2, 3'b001, 0, 1, 4);
    #2;
    reset = 1'b0;
    #1;
    check_out("async reset", 0, 0, 3'b000, 0, 0, 0);
    step();
    check_out("held reset", 0, 0, 3'b000, 0, 0, 0);
    #2;
    reset = 1'b1;
    edges = 0;
    repeat (4) step();
    check_out("post-reset filling", 0, 0, 3'b000, 0, 0, 0);
    step();
    check_out("post-reset alarm", 1, 1, 3'b001, 0, blink_bz(), 1);

    // Ack on the escalation edge wins: level never reaches 2.
    while (edges < 36) step();
    check_out("esc edge minus 1", 1, 1, 3'b001, 0, blink_bz(), 1);
    drive(1, 0, 0, 1);
    step();
    check_out("ack beats escalate", 0, 0, 3'b000, 1, 0, 1);
    drive(0, 0, 0, 0);
    step();
    check_out("snooze after tie", 0, 0, 3'b000, 1, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
